regfile_wb_scheduler: RTL and testbench

Write-port scheduler and scoreboard for the 32×32 register file in the pipelined RISC-V core. The register file has one write port. This block shares that port between the in-order pipeline writeback and a multi-cycle execution unit (divider/load miss path), which returns results out of band. It buffers multi-cycle results, tracks the destination registers they own, and gives decode a stall signal for RAW/WAW hazards on those registers. It sits between the WB stage, the multi-cycle unit, and the register file's WE3/A3/WD3 inputs.

---
 rtl/regfile_ctrl_pkg.sv | 21 ++
 rtl/regfile_wb_scheduler_if.sv | 50 +++++
 rtl/regfile_wb_scheduler_fifo.sv | 63 ++++++
 rtl/regfile_wb_scheduler.sv | 124 ++++++++++++
 tb/tb_regfile_wb_scheduler.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : regfile_ctrl_pkg
//  Description : Shared sizes and the buffered-result entry type for the
//                register-file write-port scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
package regfile_ctrl_pkg;

  localparam int XLEN       = 32;
  localparam int REG_AW     = 5;
  localparam int STARVE_MAX = 4;

  // One buffered multi-cycle result: destination register and its value.
  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } result_entry_t;

endpackage
`default_nettype wire

// File: rtl/regfile_wb_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Interface   : regfile_wb_scheduler_if
//  Description : Writeback, multi-cycle result, regfile write-port and
//                decode hazard signals of the write-port scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
interface regfile_wb_scheduler_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
);

  logic              wb_we;
  logic [REG_AW-1:0] wb_rd;
  logic [XLEN-1:0]   wb_data;
  logic              mc_issue;
  logic [REG_AW-1:0] mc_issue_rd;
  logic              mc_valid;
  logic              mc_ready;
  logic [REG_AW-1:0] mc_rd;
  logic [XLEN-1:0]   mc_data;
  logic              rf_we;
  logic [REG_AW-1:0] rf_a3;
  logic [XLEN-1:0]   rf_wd3;
  logic [REG_AW-1:0] hz_rs1;
  logic [REG_AW-1:0] hz_rs2;
  logic [REG_AW-1:0] hz_rd;
  logic              hz_stall;
  logic              drain_stall;

  // Pipeline / multi-cycle unit / decode side.
  modport master (
    output wb_we, wb_rd, wb_data,
    output mc_issue, mc_issue_rd,
    output mc_valid, mc_rd, mc_data,
    output hz_rs1, hz_rs2, hz_rd,
    input  mc_ready, rf_we, rf_a3, rf_wd3, hz_stall, drain_stall
  );

  // Scheduler side.
  modport slave (
    input  wb_we, wb_rd, wb_data,
    input  mc_issue, mc_issue_rd,
    input  mc_valid, mc_rd, mc_data,
    input  hz_rs1, hz_rs2, hz_rd,
    output mc_ready, rf_we, rf_a3, rf_wd3, hz_stall, drain_stall
  );

endinterface
`default_nettype wire

// File: rtl/regfile_wb_scheduler_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : wb_result_fifo
//  Description : Two-entry FIFO holding multi-cycle results until the
//                register-file write port is free.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_result_fifo
  import regfile_ctrl_pkg::*;
#(
  parameter type T = result_entry_t
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic i_push,
  input  wire logic i_pop,
  input  wire T     i_din,
  output T          o_head,
  output logic      o_full,
  output logic      o_empty
);

  T           r_mem [2];
  logic       r_wr_ptr;
  logic       r_rd_ptr;
  logic [1:0] r_count;

  logic w_do_push;
  logic w_do_pop;

  assign w_do_push = i_push && (r_count != 2'd2);
  assign w_do_pop  = i_pop  && (r_count != 2'd0);

  assign o_head  = r_mem[r_rd_ptr];
  assign o_full  = (r_count == 2'd2);
  assign o_empty = (r_count == 2'd0);

  // Storage write; contents need no reset since the count guards reads.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  // Pointers wrap modulo 2; a simultaneous push and pop keeps the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_do_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_do_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/regfile_wb_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_wb_scheduler
//  Description : Shares the single register-file write port between pipeline
//                writeback and buffered multi-cycle results; keeps a busy
//                scoreboard for decode hazards and a starvation counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_scheduler #(
  parameter int XLEN       = regfile_ctrl_pkg::XLEN,
  parameter int REG_AW     = regfile_ctrl_pkg::REG_AW,
  parameter int STARVE_MAX = regfile_ctrl_pkg::STARVE_MAX
) (
  input wire logic               clk,
  input wire logic               rst,
  regfile_wb_scheduler_if.slave  bus
);

  localparam int NREG  = 1 << REG_AW;
  localparam int AGE_W = $clog2(STARVE_MAX + 1);

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } entry_t;

  entry_t            w_push_entry;
  entry_t            w_head;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_wb_win;
  logic [NREG-1:0]   r_busy;
  logic [NREG-1:0]   w_busy_next;
  logic [AGE_W-1:0]  r_age;

  assign w_push_entry = '{rd: bus.mc_rd, data: bus.mc_data};

  // mc_ready is held low during reset so nothing is accepted then.
  assign bus.mc_ready = !rst && !w_full;
  assign w_push       = bus.mc_valid && bus.mc_ready;

  // Pipeline writes to x0 do not occupy the port; the head may drain instead.
  assign w_wb_win = bus.wb_we && (bus.wb_rd != '0);
  assign w_pop    = !rst && !w_wb_win && !w_empty;

  wb_result_fifo #(
    .T (entry_t)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (w_push_entry),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Write-port arbitration: pipeline first, then the buffer head (x0 head
  // is popped silently).
  always_comb begin
    bus.rf_we  = 1'b0;
    bus.rf_a3  = '0;
    bus.rf_wd3 = '0;
    if (w_wb_win) begin
      bus.rf_we  = !rst;
      bus.rf_a3  = rst ? '0 : bus.wb_rd;
      bus.rf_wd3 = rst ? '0 : bus.wb_data;
    end else if (w_pop) begin
      bus.rf_we  = (w_head.rd != '0);
      bus.rf_a3  = w_head.rd;
      bus.rf_wd3 = w_head.data;
    end
  end

  // Scoreboard next state: drain clears, issue sets, set wins on a tie.
  always_comb begin
    w_busy_next = r_busy;
    if (w_pop) begin
      w_busy_next[w_head.rd] = 1'b0;
    end
    if (bus.mc_issue && (bus.mc_issue_rd != '0)) begin
      w_busy_next[bus.mc_issue_rd] = 1'b1;
    end
    w_busy_next[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_next;
    end
  end

  // Decode hazard: any non-zero field naming a busy register stalls.
  always_comb begin
    bus.hz_stall = 1'b0;
    if (!rst) begin
      bus.hz_stall = ((bus.hz_rs1 != '0) && r_busy[bus.hz_rs1]) ||
                     ((bus.hz_rs2 != '0) && r_busy[bus.hz_rs2]) ||
                     ((bus.hz_rd  != '0) && r_busy[bus.hz_rd]);
    end
  end

  // Starvation age of the head: counts blocked cycles, saturating.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_age <= '0;
    end else if (w_empty || w_pop) begin
      r_age <= '0;
    end else if (r_age != AGE_W'(STARVE_MAX)) begin
      r_age <= r_age + AGE_W'(1);
    end
  end

  assign bus.drain_stall = !rst && !w_empty &&
                           (r_age >= AGE_W'(STARVE_MAX - 1));

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_wb_scheduler
//  Description : Directed self-checking bench for regfile_wb_scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_scheduler;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  regfile_wb_scheduler_if #(.XLEN(32), .REG_AW(5)) bus ();

  regfile_wb_scheduler #(
    .XLEN       (32),
    .REG_AW     (5),
    .STARVE_MAX (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.wb_we       = 1'b0;
    bus.wb_rd       = '0;
    bus.wb_data     = '0;
    bus.mc_issue    = 1'b0;
    bus.mc_issue_rd = '0;
    bus.mc_valid    = 1'b0;
    bus.mc_rd       = '0;
    bus.mc_data     = '0;
    bus.hz_rs1      = '0;
    bus.hz_rs2      = '0;
    bus.hz_rd       = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    #2;
    n_checks++; if (bus.rf_we !== 1'b0) begin n_fail++; $display("FAIL reset_rf_we: got %0b want 0", bus.rf_we); end
    n_checks++; if (bus.mc_ready !== 1'b0) begin n_fail++; $display("FAIL reset_mc_ready: got %0b want 0", bus.mc_ready); end
    n_checks++; if (bus.hz_stall !== 1'b0) begin n_fail++; $display("FAIL reset_hz_stall: got %0b want 0", bus.hz_stall); end
    n_checks++; if (bus.drain_stall !== 1'b0) begin n_fail++; $display("FAIL reset_drain_stall: got %0b want 0", bus.drain_stall); end
    n_checks++; if (bus.rf_a3 !== 5'd0 || bus.rf_wd3 !== 32'd0) begin n_fail++; $display("FAIL reset_a3_wd3: got %0d/%h want 0/0", bus.rf_a3, bus.rf_wd3); end
    rst = 1'b0;
    tick();
    #2;
    n_checks++; if (bus.mc_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready: got %0b want 1", bus.mc_ready); end
  endtask

  task automatic test_idle_drain();
    idle_inputs();
    bus.mc_issue = 1'b1; bus.mc_issue_rd = 5'd5;
    tick();
    bus.mc_issue = 1'b0; bus.hz_rs1 = 5'd5;
    #2;
    n_checks++; if (bus.hz_stall !== 1'b1) begin n_fail++; $display("FAIL idle_busy5_stall: got %0b want 1", bus.hz_stall); end
    tick();
    bus.mc_valid = 1'b1; bus.mc_rd = 5'd5; bus.mc_data = 32'hDEADBEEF;
    #2;
    n_checks++; if (bus.rf_we !== 1'b0) begin n_fail++; $display("FAIL idle_no_early_write: got %0b want 0", bus.rf_we); end
    tick();
    bus.mc_valid = 1'b0;
    #2;
    n_checks++; if (bus.rf_we !== 1'b1 || bus.rf_a3 !== 5'd5 || bus.rf_wd3 !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL idle_drain: got we=%0b a3=%0d wd3=%h want 1/5/deadbeef", bus.rf_we, bus.rf_a3, bus.rf_wd3); end
    n_checks++; if (bus.hz_stall !== 1'b1) begin n_fail++; $display("FAIL idle_busy_until_edge: got %0b want 1", bus.hz_stall); end
    tick();
    #2;
    n_checks++; if (bus.hz_stall !== 1'b0 || bus.rf_we !== 1'b0) begin
      n_fail++; $display("FAIL idle_after_drain: got stall=%0b we=%0b want 0/0", bus.hz_stall, bus.rf_we); end
    idle_inputs();
  endtask

  task automatic test_conflict();
    idle_inputs();
    bus.mc_valid = 1'b1; bus.mc_rd = 5'd7; bus.mc_data = 32'h0000_0077;
    tick();
    bus.mc_valid = 1'b0;
    bus.wb_we = 1'b1; bus.wb_rd = 5'd3; bus.wb_data = 32'h0000_0033;
    #2;
    n_checks++; if (bus.rf_we !== 1'b1 || bus.rf_a3 !== 5'd3 || bus.rf_wd3 !== 32'h33) begin
      n_fail++; $display("FAIL conflict_wb_wins: got we=%0b a3=%0d wd3=%h want 1/3/33", bus.rf_we, bus.rf_a3, bus.rf_wd3); end
    tick();
    bus.wb_we = 1'b0;
    #2;
    n_checks++; if (bus.rf_we !== 1'b1 || bus.rf_a3 !== 5'd7 || bus.rf_wd3 !== 32'h77) begin
      n_fail++; $display("FAIL conflict_head_next: got we=%0b a3=%0d wd3=%h want 1/7/77", bus.rf_we, bus.rf_a3, bus.rf_wd3); end
    tick();
    #2;
    n_checks++; if (bus.rf_we !== 1'b0) begin n_fail++; $display("FAIL conflict_empty: got %0b want 0", bus.rf_we); end
    idle_inputs();
  endtask

  task automatic test_starvation();
    idle_inputs();
    bus.wb_we = 1'b1; bus.wb_rd = 5'd1; bus.wb_data = 32'h1;
    bus.mc_valid = 1'b1; bus.mc_rd = 5'd10; bus.mc_data = 32'h0000_000A;
    tick();
    bus.mc_valid = 1'b0;
    tick();
    tick();
    #2;
    n_checks++; if (bus.drain_stall !== 1'b0) begin n_fail++; $display("FAIL starve_age2: got %0b want 0", bus.drain_stall); end
    tick();
    #2;
    n_checks++; if (bus.drain_stall !== 1'b1 || bus.rf_a3 !== 5'd1) begin
      n_fail++; $display("FAIL starve_age3: got ds=%0b a3=%0d want 1/1", bus.drain_stall, bus.rf_a3); end
    tick();
    tick();
    #2;
    n_checks++; if (bus.drain_stall !== 1'b1) begin n_fail++; $display("FAIL starve_saturate: got %0b want 1", bus.drain_stall); end
    bus.wb_we = 1'b0;
    #2;
    n_checks++; if (bus.rf_we !== 1'b1 || bus.rf_a3 !== 5'd10 || bus.rf_wd3 !== 32'hA) begin
      n_fail++; $display("FAIL starve_drain: got we=%0b a3=%0d wd3=%h want 1/10/a", bus.rf_we, bus.rf_a3, bus.rf_wd3); end
    tick();
    #2;
    n_checks++; if (bus.drain_stall !== 1'b0 || bus.rf_we !== 1'b0) begin
      n_fail++; $display("FAIL starve_cleared: got ds=%0b we=%0b want 0/0", bus.drain_stall, bus.rf_we); end
    // A fresh result must start counting from zero again.
    bus.wb_we = 1'b1;
    bus.mc_valid = 1'b1; bus.mc_rd = 5'd11; bus.mc_data = 32'hB;
    tick();
    bus.mc_valid = 1'b0;
    tick();
    tick();
    #2;
    n_checks++; if (bus.drain_stall !== 1'b0) begin n_fail++; $display("FAIL starve_age_restart: got %0b want 0", bus.drain_stall); end
    bus.wb_we = 1'b0;
    tick();
    idle_inputs();
  endtask

  task automatic test_hazard();
    idle_inputs();
    bus.mc_issue = 1'b1; bus.mc_issue_rd = 5'd9;
    tick();
    bus.mc_issue = 1'b0; bus.hz_rs2 = 5'd9;
    #2;
    n_checks++; if (bus.hz_stall !== 1'b1) begin n_fail++; $display("FAIL hazard_rs2: got %0b want 1", bus.hz_stall); end
    bus.hz_rs2 = 5'd0;
    #1;
    n_checks++; if (bus.hz_stall !== 1'b0) begin n_fail++; $display("FAIL hazard_x0_fields: got %0b want 0", bus.hz_stall); end
    bus.hz_rd = 5'd9;
    #1;
    n_checks++; if (bus.hz_stall !== 1'b1) begin n_fail++; $display("FAIL hazard_rd_waw: got %0b want 1", bus.hz_stall); end
    bus.hz_rd = 5'd0; bus.hz_rs1 = 5'd8;
    #1;
    n_checks++; if (bus.hz_stall !== 1'b0) begin n_fail++; $display("FAIL hazard_other_reg: got %0b want 0", bus.hz_stall); end
    bus.hz_rs1 = 5'd0;
    bus.mc_valid = 1'b1; bus.mc_rd = 5'd9; bus.mc_data = 32'h99;
    tick();
    bus.mc_valid = 1'b0;
    tick();
    bus.hz_rs1 = 5'd9;
    #2;
    n_checks++; if (bus.hz_stall !== 1'b0) begin n_fail++; $display("FAIL hazard_cleared: got %0b want 0", bus.hz_stall); end
    idle_inputs();
  endtask

  task automatic test_full();
    idle_inputs();
    bus.wb_we = 1'b1; bus.wb_rd = 5'd2; bus.wb_data = 32'h2;
    bus.mc_valid = 1'b1; bus.mc_rd = 5'd11; bus.mc_data = 32'hB1;
    tick();
    bus.mc_rd = 5'd12; bus.mc_data = 32'hB2;
    tick();
    bus.mc_rd = 5'd13; bus.mc_data = 32'hB3;
    #2;
    n_checks++; if (bus.mc_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready_low: got %0b want 0", bus.mc_ready); end
    tick();
    #2;
    n_checks++; if (bus.mc_ready !== 1'b0 || bus.rf_a3 !== 5'd2) begin
      n_fail++; $display("FAIL full_held: got ready=%0b a3=%0d want 0/2", bus.mc_ready, bus.rf_a3); end
    bus.wb_we = 1'b0;
    #2;
    n_checks++; if (bus.rf_a3 !== 5'd11 || bus.rf_wd3 !== 32'hB1 || bus.mc_ready !== 1'b0) begin
      n_fail++; $display("FAIL full_first_pop: got a3=%0d wd3=%h ready=%0b want 11/b1/0", bus.rf_a3, bus.rf_wd3, bus.mc_ready); end
    tick();
    #2;
    n_checks++; if (bus.rf_a3 !== 5'd12 || bus.rf_wd3 !== 32'hB2 || bus.mc_ready !== 1'b1) begin
      n_fail++; $display("FAIL full_second_pop: got a3=%0d wd3=%h ready=%0b want 12/b2/1", bus.rf_a3, bus.rf_wd3, bus.mc_ready); end
    tick();
    bus.mc_valid = 1'b0;
    #2;
    n_checks++; if (bus.rf_we !== 1'b1 || bus.rf_a3 !== 5'd13 || bus.rf_wd3 !== 32'hB3) begin
      n_fail++; $display("FAIL full_third: got we=%0b a3=%0d wd3=%h want 1/13/b3", bus.rf_we, bus.rf_a3, bus.rf_wd3); end
    tick();
    #2;
    n_checks++; if (bus.rf_we !== 1'b0 || bus.mc_ready !== 1'b1) begin
      n_fail++; $display("FAIL full_empty: got we=%0b ready=%0b want 0/1", bus.rf_we, bus.mc_ready); end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    idle_inputs();
    bus.mc_valid = 1'b1; bus.mc_rd = 5'd0; bus.mc_data = 32'h1;
    tick();
    bus.mc_rd = 5'd6; bus.mc_data = 32'h66;
    #2;
    n_checks++; if (bus.rf_we !== 1'b0 || bus.mc_ready !== 1'b1) begin
      n_fail++; $display("FAIL b2b_x0_head: got we=%0b ready=%0b want 0/1", bus.rf_we, bus.mc_ready); end
    tick();
    bus.mc_valid = 1'b0;
    bus.wb_we = 1'b1; bus.wb_rd = 5'd0; bus.wb_data = 32'hFFFF;
    bus.mc_issue = 1'b1; bus.mc_issue_rd = 5'd6;
    #2;
    n_checks++; if (bus.rf_we !== 1'b1 || bus.rf_a3 !== 5'd6 || bus.rf_wd3 !== 32'h66) begin
      n_fail++; $display("FAIL b2b_wb_x0_drain: got we=%0b a3=%0d wd3=%h want 1/6/66", bus.rf_we, bus.rf_a3, bus.rf_wd3); end
    tick();
    bus.wb_we = 1'b0; bus.mc_issue = 1'b0; bus.hz_rs1 = 5'd6;
    #2;
    n_checks++; if (bus.hz_stall !== 1'b1 || bus.rf_we !== 1'b0) begin
      n_fail++; $display("FAIL b2b_set_wins: got stall=%0b we=%0b want 1/0", bus.hz_stall, bus.rf_we); end
    bus.mc_valid = 1'b1; bus.mc_rd = 5'd6; bus.mc_data = 32'h67;
    tick();
    bus.mc_valid = 1'b0;
    tick();
    #2;
    n_checks++; if (bus.hz_stall !== 1'b0) begin n_fail++; $display("FAIL b2b_busy6_clear: got %0b want 0", bus.hz_stall); end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    bus.mc_issue = 1'b1; bus.mc_issue_rd = 5'd4;
    tick();
    bus.mc_issue = 1'b0;
    bus.wb_we = 1'b1; bus.wb_rd = 5'd2; bus.wb_data = 32'h2;
    bus.mc_valid = 1'b1; bus.mc_rd = 5'd20; bus.mc_data = 32'h20;
    tick();
    bus.mc_rd = 5'd21; bus.mc_data = 32'h21;
    tick();
    bus.mc_valid = 1'b0;
    #2;
    n_checks++; if (bus.mc_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_full: got %0b want 0", bus.mc_ready); end
    rst = 1'b1;
    #2;
    n_checks++; if (bus.rf_we !== 1'b0 || bus.mc_ready !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_during: got we=%0b ready=%0b want 0/0", bus.rf_we, bus.mc_ready); end
    tick();
    rst = 1'b0;
    bus.wb_we = 1'b0; bus.hz_rs1 = 5'd4;
    #2;
    n_checks++; if (bus.mc_ready !== 1'b1 || bus.hz_stall !== 1'b0 || bus.rf_we !== 1'b0 || bus.drain_stall !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_after: got ready=%0b stall=%0b we=%0b ds=%0b want 1/0/0/0",
                         bus.mc_ready, bus.hz_stall, bus.rf_we, bus.drain_stall); end
    tick();
    #2;
    n_checks++; if (bus.rf_we !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_stale: got %0b want 0", bus.rf_we); end
    idle_inputs();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    idle_inputs();
    test_reset();
    test_idle_drain();
    test_conflict();
    test_starvation();
    test_hazard();
    test_full();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
